// File: rtl/fpga_ram_bank_if.sv
// Memory-bus bundle for fpga_ram_bank: access handshake, byte-lane writes and zeroize control.
interface fpga_ram_bank_if #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32
) ();
    localparam int unsigned LANES = DATA_WIDTH / 8;

    logic                  cs;
    logic [LANES-1:0]      we;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  ready;
    logic                  zeroize;
    logic                  busy;

    modport master (
        output cs, we, address, write_data, zeroize,
        input  read_data, ready, busy
    );

    modport slave (
        input  cs, we, address, write_data, zeroize,
        output read_data, ready, busy
    );
endinterface

// File: rtl/fpga_ram_bank.sv
// Parametrised on-chip RAM bank with byte-lane writes, registered reads and a
// full-memory zeroize sweep (optionally run automatically after reset).
module fpga_ram_bank #(
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    fpga_ram_bank_if.slave bus
);
    localparam int unsigned LANES = DATA_WIDTH / 8;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] counter;
    logic                  ack;
    logic                  sweeping;
    logic [DATA_WIDTH-1:0] rdata;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [LANES-1:0]      mem_we_c;
    logic [ADDR_WIDTH-1:0] mem_addr_c;
    logic [DATA_WIDTH-1:0] mem_wdata_c;

    // Write port steering: the sweep owns the array while clearing.
    always_comb begin
        mem_we_c    = '0;
        mem_addr_c  = bus.address;
        mem_wdata_c = bus.write_data;
        if (state == CLEAR) begin
            mem_we_c    = '1;
            mem_addr_c  = counter;
            mem_wdata_c = '0;
        end else if (bus.cs && !bus.zeroize) begin
            mem_we_c = bus.we;
        end
    end

    // Array has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(LANES); i++) begin
            if (mem_we_c[i]) begin
                mem[mem_addr_c][8*i +: 8] <= mem_wdata_c[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter <= '0;
            ack     <= 1'b0;
            rdata   <= '0;
            if (CLEAR_ON_RESET) begin
                state    <= CLEAR;
                sweeping <= 1'b1;
            end else begin
                state    <= IDLE;
                sweeping <= 1'b0;
            end
        end else begin
            case (state)
                IDLE: begin
                    ack <= 1'b0;
                    if (bus.zeroize) begin
                        state    <= CLEAR;
                        sweeping <= 1'b1;
                        rdata    <= '0;
                    end else if (bus.cs) begin
                        ack <= 1'b1;
                        // Read returns the pre-edge contents of the word.
                        if (bus.we == '0) begin
                            rdata <= mem[bus.address];
                        end
                    end
                end
                CLEAR: begin
                    ack     <= 1'b0;
                    counter <= counter + ADDR_WIDTH'(1);
                    if (&counter) begin
                        state    <= IDLE;
                        sweeping <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    sweeping <= 1'b0;
                    ack      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready     = ack;
    assign bus.busy      = sweeping;
    assign bus.read_data = rdata;
endmodule

// File: tb/tb_fpga_ram_bank.sv
// Randomised self-checking bench for fpga_ram_bank (16 x 32, clear on reset).
module tb_fpga_ram_bank;
    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned WORDS = 16;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fpga_ram_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    fpga_ram_bank #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: memory contents, remaining sweep words, expected outputs.
    logic [31:0] mem_m [WORDS];
    int          sweep_left;
    logic        exp_ready;
    logic [31:0] exp_rd;

    task automatic model_reset();
        sweep_left = WORDS;
        exp_ready  = 1'b0;
        exp_rd     = 32'h0;
    endtask

    // One clock of bus activity; the model is advanced from the sampled inputs.
    task automatic step(input logic c, input logic [3:0] w, input logic [3:0] a,
                        input logic [31:0] d, input logic z);
        bus.cs         = c;
        bus.we         = w;
        bus.address    = a;
        bus.write_data = d;
        bus.zeroize    = z;
        @(posedge clk);
        if (sweep_left > 0) begin
            mem_m[WORDS - sweep_left] = 32'h0;
            sweep_left--;
            exp_ready = 1'b0;
        end else if (z) begin
            sweep_left = WORDS;
            exp_ready  = 1'b0;
            exp_rd     = 32'h0;
        end else if (c) begin
            exp_ready = 1'b1;
            if (w == 4'h0) begin
                exp_rd = mem_m[a];
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (w[i]) mem_m[a][8*i +: 8] = d[8*i +: 8];
                end
            end
        end else begin
            exp_ready = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.cs = 1'b0; bus.we = '0; bus.address = '0; bus.write_data = '0; bus.zeroize = 1'b0;
        model_reset();
        #2;
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", bus.ready); end
        checks++; if (bus.read_data !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", bus.read_data); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", bus.busy); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= int'(WORDS); k++) begin
            step(1'b1, 4'h0, 4'(k), 32'h0, 1'b0);
            checks++; if (bus.busy !== (k < int'(WORDS))) begin errors++; $display("FAIL reset_sweep_busy cycle %0d: got %b want %b", k, bus.busy, k < int'(WORDS)); end
            checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_sweep_ready cycle %0d: got %b want 0", k, bus.ready); end
        end
        for (int i = 0; i < int'(WORDS); i++) begin
            step(1'b1, 4'h0, 4'(i), 32'h0, 1'b0);
            checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_read_ready addr %0d: got %b want 1", i, bus.ready); end
            checks++; if (bus.read_data !== 32'h0) begin errors++; $display("FAIL reset_read_zero addr %0d: got %h want 00000000", i, bus.read_data); end
        end
    endtask

    task automatic test_byte_lanes();
        step(1'b1, 4'hF, 4'd3, 32'hDEADBEEF, 1'b0);
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL lanes_wr_ready: got %b want 1", bus.ready); end
        step(1'b1, 4'h0, 4'd3, 32'h0, 1'b0);
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL lanes_rd_ready: got %b want 1", bus.ready); end
        checks++; if (bus.read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL lanes_full: got %h want deadbeef", bus.read_data); end
        step(1'b0, 4'h0, 4'd0, 32'h0, 1'b0);
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL lanes_idle_ready: got %b want 0", bus.ready); end
        checks++; if (bus.read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL lanes_hold: got %h want deadbeef", bus.read_data); end
        step(1'b1, 4'b0101, 4'd3, 32'h11223344, 1'b0);
        checks++; if (bus.read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL lanes_wr_keeps_rdata: got %h want deadbeef", bus.read_data); end
        step(1'b1, 4'h0, 4'd3, 32'h0, 1'b0);
        checks++; if (bus.read_data !== 32'hDE22BE44) begin errors++; $display("FAIL lanes_partial: got %h want de22be44", bus.read_data); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        v = $urandom;
        step(1'b1, 4'hF, 4'd5, v, 1'b0);
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1: got %b want 1", bus.ready); end
        step(1'b1, 4'h0, 4'd5, 32'h0, 1'b0);
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL b2b_ready2: got %b want 1", bus.ready); end
        checks++; if (bus.read_data !== v) begin errors++; $display("FAIL b2b_rd5: got %h want %h", bus.read_data, v); end
        step(1'b1, 4'h0, 4'd3, 32'h0, 1'b0);
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL b2b_ready3: got %b want 1", bus.ready); end
        checks++; if (bus.read_data !== 32'hDE22BE44) begin errors++; $display("FAIL b2b_rd3: got %h want de22be44", bus.read_data); end
        step(1'b0, 4'h0, 4'd0, 32'h0, 1'b0);
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL b2b_drop: got %b want 0", bus.ready); end
    endtask

    task automatic test_zeroize();
        step(1'b1, 4'hF, 4'd7, 32'hA5A5A5A5, 1'b0);
        step(1'b1, 4'h0, 4'd7, 32'h0, 1'b0);
        checks++; if (bus.read_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL zero_prefill: got %h want a5a5a5a5", bus.read_data); end
        step(1'b1, 4'hF, 4'd7, 32'h5A5A5A5A, 1'b1);
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL zero_cs_ignored: got %b want 0", bus.ready); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL zero_busy_start: got %b want 1", bus.busy); end
        checks++; if (bus.read_data !== 32'h0) begin errors++; $display("FAIL zero_rdata_clr: got %h want 0", bus.read_data); end
        for (int k = 1; k <= int'(WORDS); k++) begin
            step(1'b1, 4'hF, (k % 2 == 0) ? 4'd7 : 4'd3, 32'hFFFF0000 | 32'(k), (k % 3 == 0) || (k == int'(WORDS)));
            checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL zero_sweep_ready cycle %0d: got %b want 0", k, bus.ready); end
            checks++; if (bus.busy !== (k < int'(WORDS))) begin errors++; $display("FAIL zero_sweep_busy cycle %0d: got %b want %b", k, bus.busy, k < int'(WORDS)); end
        end
        step(1'b1, 4'h0, 4'd7, 32'h0, 1'b0);
        checks++; if (bus.read_data !== 32'h0 || bus.ready !== 1'b1) begin errors++; $display("FAIL zero_rd7: got %h/%b want 00000000/1", bus.read_data, bus.ready); end
        step(1'b1, 4'h0, 4'd3, 32'h0, 1'b0);
        checks++; if (bus.read_data !== 32'h0) begin errors++; $display("FAIL zero_rd3: got %h want 00000000", bus.read_data); end
    endtask

    task automatic test_reset_mid_sweep();
        step(1'b1, 4'hF, 4'd2, 32'h12345678, 1'b0);
        step(1'b1, 4'h0, 4'd2, 32'h0, 1'b0);
        checks++; if (bus.read_data !== 32'h12345678) begin errors++; $display("FAIL rst_prefill: got %h want 12345678", bus.read_data); end
        // Mid-cycle assertion: outputs must clear without a clock edge.
        #2; rst = 1'b1; model_reset(); #1;
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL rst_async_ready: got %b want 0", bus.ready); end
        checks++; if (bus.read_data !== 32'h0) begin errors++; $display("FAIL rst_async_rdata: got %h want 0", bus.read_data); end
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < int'(WORDS); k++) step(1'b0, 4'h0, 4'd0, 32'h0, 1'b0);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_sweep_done: got %b want 0", bus.busy); end
        for (int i = 0; i < int'(WORDS); i++) step(1'b1, 4'hF, 4'(i), $urandom | 32'h1, 1'b0);
        step(1'b0, 4'h0, 4'd0, 32'h0, 1'b1);
        for (int k = 0; k < 8; k++) step(1'b0, 4'h0, 4'd0, 32'h0, 1'b0);
        #2; rst = 1'b1; model_reset(); #1;
        checks++; if (bus.busy !== 1'b1 || bus.ready !== 1'b0 || bus.read_data !== 32'h0) begin errors++; $display("FAIL rst_mid_sweep: got busy %b ready %b rdata %h want 1 0 0", bus.busy, bus.ready, bus.read_data); end
        @(negedge clk); rst = 1'b0;
        for (int k = 1; k <= int'(WORDS); k++) begin
            step(1'b0, 4'h0, 4'd0, 32'h0, 1'b0);
            checks++; if (bus.busy !== (k < int'(WORDS))) begin errors++; $display("FAIL rst_restart_busy cycle %0d: got %b want %b", k, bus.busy, k < int'(WORDS)); end
        end
        for (int i = 0; i < int'(WORDS); i++) begin
            step(1'b1, 4'h0, 4'(i), 32'h0, 1'b0);
            checks++; if (bus.read_data !== 32'h0) begin errors++; $display("FAIL rst_restart_clear addr %0d: got %h want 0", i, bus.read_data); end
        end
    endtask

    task automatic test_random();
        logic       c;
        logic       z;
        logic [3:0] w;
        for (int n = 0; n < 400; n++) begin
            c = ($urandom_range(0, 9) < 7);
            w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            z = ($urandom_range(0, 49) == 0);
            step(c, w, 4'($urandom), $urandom, z);
            checks++; if (bus.ready !== exp_ready) begin errors++; $display("FAIL rand_ready step %0d: got %b want %b", n, bus.ready, exp_ready); end
            checks++; if (bus.read_data !== exp_rd) begin errors++; $display("FAIL rand_rdata step %0d: got %h want %h", n, bus.read_data, exp_rd); end
            checks++; if (bus.busy !== (sweep_left > 0)) begin errors++; $display("FAIL rand_busy step %0d: got %b want %b", n, bus.busy, sweep_left > 0); end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_byte_lanes();
        test_back_to_back();
        test_zeroize();
        test_reset_mid_sweep();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
